scan_mux: RTL and testbench

- N-channel, W-bit registered display selector; parametrised successor to the two-way dice/traffic-lights mux.
- Two modes: manual (channel chosen by sel) and auto-scan (channels rotate every DWELL cycles).
- Optional blanking interval on every channel change, plus a one-cycle switch indication.
- Sits between source blocks (dice, traffic, counters) and the LED output.

---
 rtl/scan_mux_if.sv | 17 +
 rtl/scan_mux.sv | 112 +++++++++++
 tb/tb_scan_mux.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_mux_if.sv
// Channel data / select / display bus between the source blocks and scan_mux.
interface scan_mux_if #(
  parameter int N_CH = 4,
  parameter int W    = 3
);
  localparam int SELW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*W-1:0] din;
  logic [SELW-1:0]   sel;
  logic              auto;
  logic [W-1:0]      result;
  logic [SELW-1:0]   ch;
  logic              switch_pulse;

  modport master (output din, sel, auto, input result, ch, switch_pulse);
  modport slave  (input din, sel, auto, output result, ch, switch_pulse);
endinterface

// File: rtl/scan_mux.sv
// N-channel registered display selector with manual/auto-scan, change blanking
// and switch pulse. Optional hold input enabled by SCAN_MUX_FREEZE_EN.
module scan_mux #(
  parameter int N_CH  = 4,
  parameter int W     = 3,
  parameter int DWELL = 8,
  parameter int BLANK = 1
)(
  input  logic       clk,
  input  logic       rst,
`ifdef SCAN_MUX_FREEZE_EN
  input  logic       freeze,
`endif
  scan_mux_if.slave  bus
);
  localparam int SELW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DWW   = $clog2(DWELL + 1);
  localparam int BCW   = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam bit MULTI = (N_CH > 1);

  typedef enum logic {SHOW, BLNK} state_t;

  state_t                  state, state_nx;
  logic [SELW-1:0]         ch_q, ch_nx, target;
  logic [DWW-1:0]          dw_q, dw_nx;
  logic [BCW-1:0]          bc_q, bc_nx;
  logic [W-1:0]            res_q, res_nx;
  logic                    sp_q, sp_nx;
  logic                    req, sel_ok, hold;
  logic [N_CH-1:0][W-1:0]  din_a;

  assign din_a  = bus.din;
  assign sel_ok = {1'b0, bus.sel} < (SELW+1)'(N_CH);

`ifdef SCAN_MUX_FREEZE_EN
  assign hold = freeze;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHOW;
      ch_q  <= '0;
      dw_q  <= '0;
      bc_q  <= '0;
      res_q <= '0;
      sp_q  <= 1'b0;
    end else begin
      state <= state_nx;
      ch_q  <= ch_nx;
      dw_q  <= dw_nx;
      bc_q  <= bc_nx;
      res_q <= res_nx;
      sp_q  <= sp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch_q;
    dw_nx    = dw_q;
    bc_nx    = bc_q;
    res_nx   = res_q;
    sp_nx    = 1'b0;
    if (bus.auto) begin
      target = (ch_q == SELW'(N_CH - 1)) ? '0 : ch_q + 1'b1;
      req    = MULTI && (dw_q == DWW'(DWELL - 1));
    end else begin
      target = bus.sel;
      req    = MULTI && sel_ok && (bus.sel != ch_q);
    end
    if (!hold) begin
      unique case (state)
        SHOW: begin
          if (req) begin
            ch_nx = target;
            sp_nx = 1'b1;
            dw_nx = '0;
            if (BLANK > 0) begin
              state_nx = BLNK;
              bc_nx    = '0;
              res_nx   = '0;
            end else begin
              res_nx = din_a[target];
            end
          end else begin
            res_nx = din_a[ch_q];
            dw_nx  = bus.auto ? dw_q + 1'b1 : '0;
          end
        end
        BLNK: begin
          dw_nx = '0;
          // Exit edge already loads the new channel so result is 0 for exactly BLANK cycles.
          if (bc_q == BCW'(BLANK - 1)) begin
            state_nx = SHOW;
            bc_nx    = '0;
            res_nx   = din_a[ch_q];
          end else begin
            bc_nx  = bc_q + 1'b1;
            res_nx = '0;
          end
        end
        default: state_nx = SHOW;
      endcase
    end
  end

  assign bus.result       = res_q;
  assign bus.ch           = ch_q;
  assign bus.switch_pulse = sp_q;
endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: scoreboarded 4-channel instance plus a
// 3-channel, no-blank instance checked against hand-derived values.
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frz = 1'b0;
  always #5 clk = ~clk;

  scan_mux_if #(.N_CH(4), .W(3)) if4();
  scan_mux_if #(.N_CH(3), .W(3)) if3();

  scan_mux #(.N_CH(4), .W(3), .DWELL(8), .BLANK(1)) dut4 (
    .clk(clk), .rst(rst),
`ifdef SCAN_MUX_FREEZE_EN
    .freeze(frz),
`endif
    .bus(if4));

  scan_mux #(.N_CH(3), .W(3), .DWELL(2), .BLANK(0)) dut3 (
    .clk(clk), .rst(rst),
`ifdef SCAN_MUX_FREEZE_EN
    .freeze(frz),
`endif
    .bus(if3));

  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];
  logic [5:0] e, got;

  // reference model for dut4: blanking tracked as remaining cycles
  logic [2:0] m_res = '0;
  logic [1:0] m_ch  = '0;
  logic       m_sp  = 1'b0;
  int         m_dw  = 0;
  int         m_blank = 0;

  task automatic model_edge();
    logic [1:0] tgt;
    logic       req;
    if (rst) begin
      m_res = '0; m_ch = '0; m_sp = 1'b0; m_dw = 0; m_blank = 0;
    end else if (frz) begin
      m_sp = 1'b0;
    end else if (m_blank > 0) begin
      m_blank = m_blank - 1;
      m_sp = 1'b0;
      m_dw = 0;
      m_res = (m_blank == 0) ? if4.din[m_ch*3 +: 3] : 3'd0;
    end else begin
      tgt = if4.auto ? m_ch + 2'd1 : if4.sel;
      req = if4.auto ? (m_dw == 7) : (if4.sel != m_ch);
      if (req) begin
        m_ch = tgt; m_sp = 1'b1; m_dw = 0; m_blank = 1; m_res = '0;
      end else begin
        m_sp = 1'b0;
        m_res = if4.din[m_ch*3 +: 3];
        m_dw = if4.auto ? m_dw + 1 : 0;
      end
    end
    sb.push_back({m_res, m_ch, m_sp});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if4.din = {3'd4, 3'd3, 3'd2, 3'd1};
    if4.sel = 2'd0; if4.auto = 1'b0;
    if3.din = {3'd7, 3'd6, 3'd5};
    if3.sel = 2'd0; if3.auto = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL reset_sb got=%h exp=%h", got, e); end
    end
    checks++;
    if ({if4.result, if4.ch, if4.switch_pulse} !== 6'd0) begin
      errors++; $display("FAIL reset_vals got=%h exp=0", {if4.result, if4.ch, if4.switch_pulse});
    end
    rst = 1'b0;
    tick();
    e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
    if (got !== e) begin errors++; $display("FAIL reset_first_sb got=%h exp=%h", got, e); end
    checks++;
    if (if4.result !== 3'd1 || if4.ch !== 2'd0 || if4.switch_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_first res=%0d ch=%0d sp=%b exp 1/0/0", if4.result, if4.ch, if4.switch_pulse);
    end
  endtask

  task automatic test_manual();
    logic [1:0] sels[6] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      if4.sel = sels[i];
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL manual_sb step=%0d got=%h exp=%h", i, got, e); end
      if (i == 0) begin
        checks++;
        if (if4.ch !== 2'd2 || if4.switch_pulse !== 1'b1 || if4.result !== 3'd0) begin
          errors++; $display("FAIL manual_switch ch=%0d sp=%b res=%0d exp 2/1/0", if4.ch, if4.switch_pulse, if4.result);
        end
      end
      if (i == 1) begin
        checks++;
        if (if4.result !== 3'd3 || if4.switch_pulse !== 1'b0) begin
          errors++; $display("FAIL manual_show res=%0d sp=%b exp 3/0", if4.result, if4.switch_pulse);
        end
      end
      if (i == 3) begin
        checks++;
        if (if4.ch !== 2'd3 || if4.result !== 3'd4) begin
          errors++; $display("FAIL sel_in_blank ch=%0d res=%0d exp 3/4", if4.ch, if4.result);
        end
      end
    end
    if4.sel = 2'd0;
    repeat (2) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL manual_back_sb got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_auto();
    int npulse = 0;
    int last = 0;
    logic [1:0] exp_ch = 2'd1;
    if4.auto = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL auto_sb cyc=%0d got=%h exp=%h", i, got, e); end
      if (if4.switch_pulse === 1'b1) begin
        checks++;
        if (i - last !== (npulse == 0 ? 8 : 9) || if4.ch !== exp_ch) begin
          errors++; $display("FAIL auto_period gap=%0d ch=%0d exp_ch=%0d", i - last, if4.ch, exp_ch);
        end
        last = i; npulse++; exp_ch = exp_ch + 2'd1;
      end
    end
    checks++;
    if (npulse !== 4) begin errors++; $display("FAIL auto_count got=%0d exp=4", npulse); end
    // drop to manual mid-dwell, then back: dwell must restart from 0
    if4.auto = 1'b0; if4.sel = if4.ch;
    repeat (3) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL auto_off_sb got=%h exp=%h", got, e); end
    end
    if4.auto = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL auto_on_sb cyc=%0d got=%h exp=%h", i, got, e); end
      checks++;
      if (if4.switch_pulse !== (i == 8)) begin
        errors++; $display("FAIL auto_restart cyc=%0d sp=%b", i, if4.switch_pulse);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
    if (got !== 6'd0 || e !== 6'd0) begin errors++; $display("FAIL rst_in_blank got=%h exp=0", got); end
    rst = 1'b0;
    repeat (5) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL rst_dwell_sb got=%h exp=%h", got, e); end
    end
    rst = 1'b1;
    tick();
    e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
    if (got !== 6'd0 || e !== 6'd0) begin errors++; $display("FAIL rst_in_dwell got=%h exp=0", got); end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL rst_resume_sb cyc=%0d got=%h exp=%h", i, got, e); end
    end
    checks++;
    if (if4.ch !== 2'd1 || if4.switch_pulse !== 1'b1) begin
      errors++; $display("FAIL rst_resume ch=%0d sp=%b exp 1/1", if4.ch, if4.switch_pulse);
    end
  endtask

  task automatic test_out_of_range();
    // each row: sel, auto, ch1 data, expected {result, ch, sp}
    logic [1:0] sel_t[9]  = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    logic       auto_t[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] d1_t[9]   = '{3'd6, 3'd6, 3'd6, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    logic [5:0] exp_t[9]  = '{{3'd6, 2'd1, 1'b1}, {3'd6, 2'd1, 1'b0}, {3'd6, 2'd1, 1'b0},
                              {3'd2, 2'd1, 1'b0}, {3'd2, 2'd1, 1'b0}, {3'd7, 2'd2, 1'b1},
                              {3'd7, 2'd2, 1'b0}, {3'd5, 2'd0, 1'b1}, {3'd5, 2'd0, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      if3.sel = sel_t[i]; if3.auto = auto_t[i]; if3.din[5:3] = d1_t[i];
      tick();
      void'(sb.pop_front());
      got = {if3.result, if3.ch, if3.switch_pulse}; checks++;
      if (got !== exp_t[i]) begin errors++; $display("FAIL n3_step%0d got=%h exp=%h", i, got, exp_t[i]); end
    end
  endtask

`ifdef SCAN_MUX_FREEZE_EN
  task automatic test_freeze();
    rst = 1'b1; tick(); void'(sb.pop_front());
    rst = 1'b0; if4.auto = 1'b1;
    repeat (6) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e) begin errors++; $display("FAIL frz_pre_sb got=%h exp=%h", got, e); end
    end
    frz = 1'b1; if4.din[2:0] = 3'd5;
    repeat (10) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== {3'd1, 2'd0, 1'b0} || got !== e) begin
        errors++; $display("FAIL frz_hold got=%h exp=%h", got, e);
      end
    end
    frz = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      e = sb.pop_front(); got = {if4.result, if4.ch, if4.switch_pulse}; checks++;
      if (got !== e || if4.switch_pulse !== (i == 2)) begin
        errors++; $display("FAIL frz_release cyc=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_mid_reset();
    test_out_of_range();
`ifdef SCAN_MUX_FREEZE_EN
    test_freeze();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
